btb_controller: RTL

Single-port access controller for the direct-mapped branch target buffer (BTB) array. It arbitrates each cycle's single array slot between fetch-stage lookups and execute-stage resolution updates, which are buffered in a small FIFO. It sequences a full-array invalidate walk after reset and on request. It sits between fetch/execute and the BTB storage, and is the only block that drives the array's access port.

---
 rtl/btb_pkg.sv | 27 ++
 rtl/btb_controller_if.sv | 54 +++++
 rtl/btb_update_fifo.sv | 58 +++++
 rtl/btb_controller.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// BTB controller shared types.
// Entry/update bundles, FSM states and index-width helper.
package btb_pkg;

  typedef struct packed {
    logic [31:2] tag;
    logic [31:2] target;
    logic        valid;
  } btb_entry_t;

  typedef struct packed {
    logic [31:2] pc;
    logic [31:2] target;
    logic        taken;
  } btb_update_t;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_IDLE  = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/btb_controller_if.sv
// BTB controller bus: fetch lookup, execute resolve,
// flush control and the single-port array access.
interface btb_controller_if #(
  parameter int IDX_W = 10
);
  logic             lookup_valid;
  logic [31:2]      lookup_pc;
  logic             lookup_ready;
  logic             pred_valid;
  logic             pred_hit;
  logic [31:2]      pred_target;
  logic             resolve_valid;
  logic [31:2]      resolve_pc;
  logic [31:2]      resolve_target;
  logic             resolve_taken;
  logic             resolve_ready;
  logic             flush_req;
  logic             flush_busy;
  logic             arr_en;
  logic             arr_we;
  logic [IDX_W-1:0] arr_idx;
  logic [31:2]      arr_wtag;
  logic [31:2]      arr_wtarget;
  logic             arr_wvalid;
  logic [31:2]      arr_rtag;
  logic [31:2]      arr_rtarget;
  logic             arr_rvalid;

  modport slave (
    input  lookup_valid, lookup_pc,
    input  resolve_valid, resolve_pc,
    input  resolve_target, resolve_taken,
    input  flush_req,
    input  arr_rtag, arr_rtarget, arr_rvalid,
    output lookup_ready,
    output pred_valid, pred_hit, pred_target,
    output resolve_ready, flush_busy,
    output arr_en, arr_we, arr_idx,
    output arr_wtag, arr_wtarget, arr_wvalid
  );

  modport master (
    output lookup_valid, lookup_pc,
    output resolve_valid, resolve_pc,
    output resolve_target, resolve_taken,
    output flush_req,
    output arr_rtag, arr_rtarget, arr_rvalid,
    input  lookup_ready,
    input  pred_valid, pred_hit, pred_target,
    input  resolve_ready, flush_busy,
    input  arr_en, arr_we, arr_idx,
    input  arr_wtag, arr_wtarget, arr_wvalid
  );
endinterface

// File: rtl/btb_update_fifo.sv
// Small FIFO buffering resolved-branch updates.
// Flush discards contents and any same-cycle push.
module btb_update_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_push,
  input  btb_update_t i_data,
  input  logic        i_pop,
  output btb_update_t o_head,
  output logic        o_full,
  output logic        o_empty
);
  localparam int PW = $clog2(DEPTH);

  btb_update_t   r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [PW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && (!o_full || i_pop);
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push && !i_flush)
      r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/btb_controller.sv
// Single-port BTB access controller: arbitrates lookups
// against buffered updates and walks invalidates on flush.
module btb_controller
  import btb_pkg::*;
#(
  parameter int NUM_ENTRIES  = 1024,
  parameter int UPD_DEPTH    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  btb_controller_if.slave  bus
);
  localparam int IDX_W = idx_w(NUM_ENTRIES);
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [SW-1:0]    r_starve;
  logic             r_pred_valid;
  logic [31:2]      r_lk_pc;

  btb_update_t w_head;
  btb_update_t w_din;
  btb_entry_t  w_wr;
  logic        w_full;
  logic        w_empty;
  logic        w_idle;
  logic        w_starve;
  logic        w_grant;
  logic        w_pop;
  logic        w_push;
  logic        w_enter_flush;
  logic        w_fifo_flush;
  logic        w_hit;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_starve = w_full ||
    ((r_starve == SW'(STARVE_LIMIT)) && !w_empty);
  assign w_grant  = w_idle && !w_starve &&
    bus.lookup_valid;
  assign w_pop    = w_idle && !w_empty &&
    (w_starve || !bus.lookup_valid);
  assign w_push   = bus.resolve_valid &&
    bus.resolve_ready;

  // A push in the flush_req cycle is dropped with the rest.
  assign w_enter_flush = w_idle && bus.flush_req;
  assign w_fifo_flush  = !w_idle || w_enter_flush;

  assign bus.lookup_ready  = w_idle && !w_starve;
  assign bus.resolve_ready = w_idle && !w_full;
  assign bus.flush_busy    = !w_idle;

  assign w_din.pc     = bus.resolve_pc;
  assign w_din.target = bus.resolve_target;
  assign w_din.taken  = bus.resolve_taken;

  btb_update_fifo #(
    .DEPTH (UPD_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_fifo_flush),
    .i_push  (w_push),
    .i_data  (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Not-taken clears valid at the index, aliases included.
  assign w_wr.tag    = w_head.taken ? w_head.pc : '0;
  assign w_wr.target = w_head.taken ? w_head.target : '0;
  assign w_wr.valid  = w_head.taken;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_INIT:  w_state_nxt = ST_FLUSH;
      ST_FLUSH: begin
        if (r_idx == IDX_W'(NUM_ENTRIES - 1))
          w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.flush_req)
          w_state_nxt = ST_FLUSH;
      end
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    bus.arr_en      = 1'b0;
    bus.arr_we      = 1'b0;
    bus.arr_idx     = '0;
    bus.arr_wtag    = '0;
    bus.arr_wtarget = '0;
    bus.arr_wvalid  = 1'b0;
    unique case (1'b1)
      (r_state == ST_FLUSH): begin
        bus.arr_en  = 1'b1;
        bus.arr_we  = 1'b1;
        bus.arr_idx = r_idx;
      end
      w_pop: begin
        bus.arr_en      = 1'b1;
        bus.arr_we      = 1'b1;
        bus.arr_idx     = w_head.pc[IDX_W+1:2];
        bus.arr_wtag    = w_wr.tag;
        bus.arr_wtarget = w_wr.target;
        bus.arr_wvalid  = w_wr.valid;
      end
      w_grant: begin
        bus.arr_en  = 1'b1;
        bus.arr_idx = bus.lookup_pc[IDX_W+1:2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_INIT;
      r_idx        <= '0;
      r_starve     <= '0;
      r_pred_valid <= 1'b0;
      r_lk_pc      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= (r_state == ST_FLUSH) ?
                      r_idx + 1'b1 : '0;
      r_pred_valid <= w_grant;
      if (w_grant)
        r_lk_pc <= bus.lookup_pc;
      if (!w_idle || w_pop || w_empty ||
          w_enter_flush)
        r_starve <= '0;
      else if (w_grant &&
               r_starve != SW'(STARVE_LIMIT))
        r_starve <= r_starve + 1'b1;
    end
  end

  assign w_hit = r_pred_valid && bus.arr_rvalid &&
    (bus.arr_rtag == r_lk_pc);

  assign bus.pred_valid  = r_pred_valid;
  assign bus.pred_hit    = w_hit;
  assign bus.pred_target = w_hit ? bus.arr_rtarget : '0;

endmodule
